// File: rtl/multiscale_window_sum_pkg.sv
// Shared definitions for the multiscale window accumulator.
// Level numbering, width helper and level-select encoding.
package multiscale_window_sum_pkg;

    localparam int NLVL = 4;

    typedef enum logic [1:0] {
        LVL_0 = 2'd0,
        LVL_1 = 2'd1,
        LVL_2 = 2'd2,
        LVL_3 = 2'd3
    } lvl_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int ms_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Accumulator width of a level that sums 'depth' values of width 'w'.
    function automatic int grow_w(input int w, input int depth);
        return w + ms_clog2(depth);
    endfunction

endpackage

// File: rtl/multiscale_window_sum_window_sum_stage.sv
// Sliding-window sum over the last DEPTH strobed inputs.
// Emits a decimated strobe every DEPTH pushes once the window is full.
module window_sum_stage
    import multiscale_window_sum_pkg::*;
#(
    parameter int IN_W  = 25,
    parameter int DEPTH = 5,
    parameter int SUM_W = IN_W + ms_clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_stb,
    input  logic signed [IN_W-1:0]  i_data,
    output logic signed [SUM_W-1:0] o_sum,
    output logic                    o_stb,
    output logic                    o_upd,
    output logic                    o_full
);

    localparam int CW = ms_clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    logic signed [IN_W-1:0]  r_sr [DEPTH];
    logic signed [SUM_W-1:0] r_sum;
    logic [CW-1:0]           r_fill;
    logic [CW-1:0]           r_dec;
    logic                    r_stb;
    logic                    r_upd;

    logic signed [SUM_W-1:0] w_new;
    logic signed [SUM_W-1:0] w_old;
    logic                    w_full_next;

    // Oldest slot is still zero from reset until DEPTH pushes have landed.
    assign w_new       = SUM_W'(i_data);
    assign w_old       = SUM_W'(r_sr[DEPTH-1]);
    assign w_full_next = (r_fill >= LAST_C);

    // Shift register, running sum, fill and decimation counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
            r_sum  <= '0;
            r_fill <= '0;
            r_dec  <= '0;
            r_stb  <= 1'b0;
            r_upd  <= 1'b0;
        end else begin
            r_upd <= i_stb;
            r_stb <= 1'b0;
            if (i_stb) begin
                r_sr[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    r_sr[i] <= r_sr[i-1];
                end
                r_sum <= r_sum + w_new - w_old;
                if (r_fill != DEPTH_C) begin
                    r_fill <= r_fill + CW'(1);
                end
                if (r_dec == LAST_C) begin
                    r_dec <= '0;
                    r_stb <= w_full_next;
                end else begin
                    r_dec <= r_dec + CW'(1);
                end
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_stb  = r_stb;
    assign o_upd  = r_upd;
    assign o_full = (r_fill == DEPTH_C);

endmodule

// File: rtl/multiscale_window_sum.sv
// Four-level cascaded window accumulator for line-length features.
// Level 0 block-sums samples; levels 1..3 slide over the level below.
module multiscale_window_sum
    import multiscale_window_sum_pkg::*;
#(
    parameter int IN_W      = 25,
    parameter int BASE_N    = 250,
    parameter int R1        = 5,
    parameter int R2        = 6,
    parameter int R3        = 8,
    parameter int OUT_W     = 25,
    parameter int OUT_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    din_valid,
    input  logic signed [IN_W-1:0]  din,
    input  logic [1:0]              lvl_sel,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic [NLVL-1:0]         lvl_full,
    output logic                    sat
);

    localparam int W0 = grow_w(IN_W, BASE_N);
    localparam int W1 = grow_w(W0, R1);
    localparam int W2 = grow_w(W1, R2);
    localparam int W3 = grow_w(W2, R3);
    localparam int WC = ((W3 > OUT_W) ? W3 : OUT_W) + 1;
    localparam int CW0 = ms_clog2(BASE_N + 1);
    localparam logic [CW0-1:0] LAST0 = CW0'(BASE_N - 1);

    localparam logic signed [WC-1:0] MAXV =
        {{(WC-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WC-1:0] MINV = ~MAXV;

    // Level 0 state.
    logic [CW0-1:0]          r_cnt;
    logic signed [W0-1:0]    r_acc;
    logic signed [W0-1:0]    r_s0;
    logic                    r_s0_stb;
    logic                    r_full0;

    // Output state.
    logic signed [OUT_W-1:0] r_dout;
    logic                    r_dout_valid;
    logic                    r_sat;

    logic                    w_accept;
    logic signed [W0-1:0]    w_acc_sum;

    logic signed [W1-1:0]    w_s1;
    logic signed [W2-1:0]    w_s2;
    logic signed [W3-1:0]    w_s3;
    logic                    w_s1_stb;
    logic                    w_s2_stb;
    logic                    w_unused_s3_stb;
    logic                    w_upd1;
    logic                    w_upd2;
    logic                    w_upd3;
    logic                    w_full1;
    logic                    w_full2;
    logic                    w_full3;

    logic signed [WC-1:0]    w_sel;
    logic                    w_sel_upd;
    logic                    w_sel_full;
    logic signed [WC-1:0]    w_shift;
    logic                    w_hi;
    logic                    w_lo;
    logic signed [OUT_W-1:0] w_clip;
    logic                    w_load;

    // en is active-low: it only blocks new samples.
    assign w_accept  = din_valid && !en;
    assign w_acc_sum = r_acc + W0'(din);

    // Level 0: block sum over BASE_N accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_s0     <= '0;
            r_s0_stb <= 1'b0;
            r_full0  <= 1'b0;
        end else begin
            r_s0_stb <= 1'b0;
            if (w_accept) begin
                if (r_cnt == LAST0) begin
                    r_s0     <= w_acc_sum;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_s0_stb <= 1'b1;
                    r_full0  <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + CW0'(1);
                end
            end
        end
    end

    window_sum_stage #(
        .IN_W  (W0),
        .DEPTH (R1),
        .SUM_W (W1)
    ) u_lvl1 (
        .clk    (clk),
        .rst    (rst),
        .i_stb  (r_s0_stb),
        .i_data (r_s0),
        .o_sum  (w_s1),
        .o_stb  (w_s1_stb),
        .o_upd  (w_upd1),
        .o_full (w_full1)
    );

    window_sum_stage #(
        .IN_W  (W1),
        .DEPTH (R2),
        .SUM_W (W2)
    ) u_lvl2 (
        .clk    (clk),
        .rst    (rst),
        .i_stb  (w_s1_stb),
        .i_data (w_s1),
        .o_sum  (w_s2),
        .o_stb  (w_s2_stb),
        .o_upd  (w_upd2),
        .o_full (w_full2)
    );

    window_sum_stage #(
        .IN_W  (W2),
        .DEPTH (R3),
        .SUM_W (W3)
    ) u_lvl3 (
        .clk    (clk),
        .rst    (rst),
        .i_stb  (w_s2_stb),
        .i_data (w_s2),
        .o_sum  (w_s3),
        .o_stb  (w_unused_s3_stb),
        .o_upd  (w_upd3),
        .o_full (w_full3)
    );

    // Route the selected level's sum, update strobe and full flag.
    always_comb begin
        w_sel      = '0;
        w_sel_upd  = 1'b0;
        w_sel_full = 1'b0;
        unique case (lvl_e'(lvl_sel))
            LVL_0: begin
                w_sel      = WC'(r_s0);
                w_sel_upd  = r_s0_stb;
                w_sel_full = r_full0;
            end
            LVL_1: begin
                w_sel      = WC'(w_s1);
                w_sel_upd  = w_upd1;
                w_sel_full = w_full1;
            end
            LVL_2: begin
                w_sel      = WC'(w_s2);
                w_sel_upd  = w_upd2;
                w_sel_full = w_full2;
            end
            LVL_3: begin
                w_sel      = WC'(w_s3);
                w_sel_upd  = w_upd3;
                w_sel_full = w_full3;
            end
            default: begin
                w_sel      = '0;
                w_sel_upd  = 1'b0;
                w_sel_full = 1'b0;
            end
        endcase
    end

    assign w_shift = w_sel >>> OUT_SHIFT;
    assign w_hi    = (w_shift > MAXV);
    assign w_lo    = (w_shift < MINV);
    assign w_clip  = w_hi ? MAXV[OUT_W-1:0] :
                     w_lo ? MINV[OUT_W-1:0] :
                     w_shift[OUT_W-1:0];
    assign w_load  = w_sel_upd && w_sel_full;

    // Register dout on the selected level's update; track sticky clamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_dout_valid <= w_load;
            if (w_load) begin
                r_dout <= w_clip;
                if (w_hi || w_lo) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign lvl_full   = {w_full3, w_full2, w_full1, r_full0};
    assign sat        = r_sat;

endmodule

// File: tb/tb_multiscale_window_sum.sv
// Bench for multiscale_window_sum: directed cases plus random
// stimulus checked every cycle against a list-based window model.
module tb_multiscale_window_sum;

    localparam int IN_W      = 16;
    localparam int BASE_N    = 4;
    localparam int R1        = 2;
    localparam int R2        = 3;
    localparam int R3        = 2;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic din_valid = 1'b0;
    logic signed [IN_W-1:0] din = '0;
    logic [1:0] lvl_sel = 2'd0;

    logic signed [OUT_W-1:0] dout;
    logic dout_valid;
    logic [3:0] lvl_full;
    logic sat;

    logic signed [7:0] dout8;
    logic dout_valid8;
    logic [3:0] lvl_full8;
    logic sat8;

    always #5 clk = ~clk;

    multiscale_window_sum #(
        .IN_W(IN_W), .BASE_N(BASE_N), .R1(R1), .R2(R2), .R3(R3),
        .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din_valid(din_valid),
        .din(din), .lvl_sel(lvl_sel), .dout(dout),
        .dout_valid(dout_valid), .lvl_full(lvl_full), .sat(sat)
    );

    multiscale_window_sum #(
        .IN_W(IN_W), .BASE_N(BASE_N), .R1(R1), .R2(R2), .R3(R3),
        .OUT_W(8), .OUT_SHIFT(OUT_SHIFT)
    ) dut8 (
        .clk(clk), .rst(rst), .en(en), .din_valid(din_valid),
        .din(din), .lvl_sel(lvl_sel), .dout(dout8),
        .dout_valid(dout_valid8), .lvl_full(lvl_full8), .sat(sat8)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     cyc;
        int     lvl;
        longint val;
        bit     full;
    } ev_t;

    typedef struct {
        int        cyc;
        longint    val;
        logic [3:0] full;
    } cap_t;

    longint blocks[$];
    longint p2[$];
    longint p3[$];
    ev_t    evq[$];
    cap_t   cap[$];
    longint bacc;
    int     bn;
    bit [3:0] mfull;
    longint mdout;
    bit     mvalid;
    bit     msat;

    function automatic longint tail_sum(input longint q[$], input int n);
        longint s = 0;
        for (int i = 0; i < n && i < q.size(); i++) begin
            s += q[q.size()-1-i];
        end
        return s;
    endfunction

    function automatic longint clampv(input longint v);
        longint s = v >>> OUT_SHIFT;
        longint hi = (64'sd1 <<< (OUT_W-1)) - 1;
        longint lo = -hi - 1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic bit clipped(input longint v);
        return clampv(v) != (v >>> OUT_SHIFT);
    endfunction

    task automatic model_reset();
        blocks.delete();
        p2.delete();
        p3.delete();
        evq.delete();
        bacc = 0;
        bn = 0;
        mfull = '0;
        mdout = 0;
        mvalid = 0;
        msat = 0;
    endtask

    task automatic add_ev(input int c, input int l, input longint v,
                          input bit f);
        ev_t e;
        e.cyc = c;
        e.lvl = l;
        e.val = v;
        e.full = f;
        evq.push_back(e);
    endtask

    task automatic model_step();
        ev_t keep[$];
        longint v1, v2, v3;
        bit f1, f2, f3;
        if (rst) begin
            model_reset();
            return;
        end
        mvalid = 0;
        foreach (evq[i]) begin
            if (evq[i].cyc == cyc - 1 && evq[i].lvl == int'(lvl_sel)
                && evq[i].full) begin
                mvalid = 1;
                mdout = clampv(evq[i].val);
                if (clipped(evq[i].val)) msat = 1;
            end
        end
        if (din_valid && !en) begin
            bacc += longint'(din);
            bn++;
            if (bn == BASE_N) begin
                blocks.push_back(bacc);
                add_ev(cyc, 0, bacc, 1);
                bacc = 0;
                bn = 0;
                v1 = tail_sum(blocks, R1);
                f1 = blocks.size() >= R1;
                add_ev(cyc + 1, 1, v1, f1);
                if (f1 && blocks.size() % R1 == 0) begin
                    p2.push_back(v1);
                    v2 = tail_sum(p2, R2);
                    f2 = p2.size() >= R2;
                    add_ev(cyc + 2, 2, v2, f2);
                    if (f2 && p2.size() % R2 == 0) begin
                        p3.push_back(v2);
                        v3 = tail_sum(p3, R3);
                        f3 = p3.size() >= R3;
                        add_ev(cyc + 3, 3, v3, f3);
                    end
                end
            end
        end
        foreach (evq[i]) begin
            if (evq[i].cyc == cyc && evq[i].full) mfull[evq[i].lvl] = 1;
        end
        foreach (evq[i]) begin
            if (evq[i].cyc >= cyc) keep.push_back(evq[i]);
        end
        evq = keep;
    endtask

    // Model update on each edge, compare shortly after it.
    always @(posedge clk) begin
        cap_t c;
        cyc = cyc + 1;
        model_step();
        #1;
        chk("dout_valid", longint'(dout_valid), longint'(mvalid));
        chk("dout", longint'(dout), mdout);
        chk("lvl_full", longint'(lvl_full), longint'(mfull));
        chk("sat", longint'(sat), longint'(msat));
        if (dout_valid) begin
            c.cyc = cyc;
            c.val = longint'(dout);
            c.full = lvl_full;
            cap.push_back(c);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic v, input logic e, input int d);
        @(negedge clk);
        rst = 1'b0;
        din_valid = v;
        en = e;
        din = IN_W'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic longint cap_val(input int i);
        if (i < cap.size()) return cap[i].val;
        return -999999;
    endfunction

    function automatic int cap_cyc(input int i);
        if (i < cap.size()) return cap[i].cyc;
        return -999999;
    endfunction

    int start;

    initial begin
        @(negedge clk);
        rst = 1'b0;

        // 1: level 3 first output after 48 samples + pipeline.
        do_reset();
        lvl_sel = 2'd3;
        cap.delete();
        step(1'b1, 1'b0, 1);
        start = cyc + 1;
        repeat (47) step(1'b1, 1'b0, 1);
        idle(8);
        chk("t1_npulse", cap.size(), 1);
        chk("t1_latency", cap_cyc(0) - start, 51);
        chk("t1_dout", cap_val(0), 48);
        chk("t1_full", (cap.size() > 0) ? longint'(cap[0].full) : -1, 15);

        // 2: level 1 sliding sums of blocks 4, 8, 12.
        do_reset();
        lvl_sel = 2'd1;
        cap.delete();
        for (int b = 1; b <= 3; b++) begin
            repeat (4) step(1'b1, 1'b0, b);
        end
        idle(6);
        chk("t2_npulse", cap.size(), 2);
        chk("t2_dout_a", cap_val(0), 12);
        chk("t2_dout_b", cap_val(1), 20);

        // 3: negative constant on level 0.
        do_reset();
        lvl_sel = 2'd0;
        cap.delete();
        repeat (12) step(1'b1, 1'b0, -5);
        idle(4);
        chk("t3_npulse", cap.size(), 3);
        for (int i = 0; i < 3; i++) chk("t3_dout", cap_val(i), -20);
        chk("t3_spacing", cap_cyc(1) - cap_cyc(0), 4);

        // 4: en high every other cycle halves the accept rate.
        do_reset();
        lvl_sel = 2'd0;
        cap.delete();
        for (int i = 0; i < 32; i++) step(1'b1, 1'(i % 2), 1);
        idle(4);
        chk("t4_npulse", cap.size(), 4);
        chk("t4_dout", cap_val(3), 4);
        chk("t4_spacing", cap_cyc(2) - cap_cyc(1), 8);

        // 5: reset discards a partial block.
        cap.delete();
        repeat (3) step(1'b1, 1'b0, 1);
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("t5_rst_dout", longint'(dout), 0);
        chk("t5_rst_valid", longint'(dout_valid), 0);
        chk("t5_rst_full", longint'(lvl_full), 0);
        chk("t5_rst_sat", longint'(sat), 0);
        repeat (4) step(1'b1, 1'b0, 2);
        idle(4);
        chk("t5_npulse", cap.size(), 1);
        chk("t5_dout", cap_val(0), 8);

        // 6: 8-bit output clamps both ways; sat sticks.
        do_reset();
        lvl_sel = 2'd0;
        chk("t6_sat0", longint'(sat8), 0);
        repeat (8) step(1'b1, 1'b0, 100);
        idle(3);
        chk("t6_dout_hi", longint'(dout8), 127);
        chk("t6_sat_hi", longint'(sat8), 1);
        repeat (8) step(1'b1, 1'b0, -100);
        idle(3);
        chk("t6_dout_lo", longint'(dout8), -128);
        chk("t6_sat_lo", longint'(sat8), 1);

        // Random phase, model-checked every cycle.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            din_valid = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) lvl_sel = 2'($urandom);
            if ($urandom_range(0, 3) == 0)
                din = IN_W'($urandom);
            else
                din = IN_W'(int'($urandom_range(0, 100)) - 50);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
